imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter SHIFT_DECODE, default 1, meaning 1 = shift amounts decoded as type SHAMT, 0 = shifts treated as plain I-type.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning synchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  meaning discard all buffered entries.
REQ-006 SHALL have port in_valid  input  1  meaning an instruction is offered.
REQ-007 SHALL have port in_ready  output  1  meaning the block accepts the offered instruction this cycle.
REQ-008 SHALL have port in_instr  input  32  meaning the instruction word.
REQ-009 SHALL have port in_pc  input  XLEN  meaning the instruction address.
REQ-010 SHALL have port out_valid  output  1  meaning a decoded entry is presented.
REQ-011 SHALL have port out_ready  input  1  meaning the consumer takes the presented entry.
REQ-012 SHALL have port out_imm  output  XLEN  meaning the generated immediate.
REQ-013 SHALL have port out_type  output  3  meaning the immediate class: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 CSRZ.
REQ-014 SHALL have port out_target  output  XLEN  meaning in_pc+imm for B, J and AUIPC, else 0.
REQ-015 SHALL have port out_illegal  output  1  meaning the opcode is unsupported.

Function
REQ-016 SHALL accept an entry (push) when in_valid and in_ready are both 1, and present it (pop) when out_valid and out_ready are both 1.
REQ-017 SHALL buffer entries in a 2-entry FIFO with occupancy count 0..2; out_valid = (count != 0).
REQ-018 SHALL drive in_ready = (count != 2) from registered state only, with no combinational path from out_ready.
REQ-019 SHALL present a pushed entry on the outputs no earlier than the next cycle, giving 1-cycle latency when the buffer is empty.
REQ-020 SHALL sustain 1 entry/cycle throughput while out_ready is held at 1, and SHALL preserve FIFO order.
REQ-021 SHALL, on simultaneous push and pop at count 1, keep count at 1 and present the newer entry next cycle.
REQ-022 SHALL hold out_imm, out_type, out_target and out_illegal stable while out_valid=1 and out_ready=0.
REQ-023 SHALL decode I-type (OP-IMM 0010011, LOAD 0000011, JALR 1100111, and for XLEN=64 OP-IMM-32 0011011) as sext(instr[31:20]).
REQ-024 SHALL decode S-type (0100011) as sext({instr[31:25], instr[11:7]}).
REQ-025 SHALL decode B-type (1100011) as sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
REQ-026 SHALL decode U-type (LUI 0110111, AUIPC 0010111) as sext({instr[31:12], 12'b0}) to XLEN.
REQ-027 SHALL decode J-type (1101111) as sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
REQ-028 SHALL, when SHIFT_DECODE=1 and OP-IMM funct3 is 001 or 101, produce type SHAMT with imm = zext(instr[24:20]) for XLEN=32, zext(instr[25:20]) for XLEN=64, and zext(instr[24:20]) for OP-IMM-32.
REQ-029 SHALL decode SYSTEM (1110011) with funct3[2]=1 as type CSRZ, imm = zext(instr[19:15]); all other SYSTEM encodings SHALL give NONE with imm 0.
REQ-030 SHALL decode R-type (OP 0110011, and for XLEN=64 OP-32 0111011) as NONE with imm 0.
REQ-031 SHALL, for any other opcode or instr[1:0] != 2'b11, set out_illegal=1, type NONE, imm 0 and target 0.
REQ-032 SHALL compute out_target modulo 2^XLEN, with wrap-around and no overflow flag.
REQ-033 SHALL, when flush=1, set count to 0 at the next edge, discard any same-cycle push, and leave in_ready reflecting the pre-flush count during the flush cycle.

Reset
REQ-034 SHALL, while rst_n=0 at a clock edge, set count to 0, and SHALL drive out_valid=0, in_ready=0, out_imm=0, out_type=0, out_target=0 and out_illegal=0.
REQ-035 SHALL assert in_ready=1 in the first cycle after rst_n returns to 1; a reset mid-stream SHALL drop all buffered entries.
REQ-036 SHALL give reset priority over flush, push and pop.

Verification
REQ-037 Bench SHALL check: addi x1,x0,-1 (0xFFF00093), pc 0 -> next cycle out_imm=0xFFFFFFFF, type=1, target=0.
REQ-038 Bench SHALL check: beq, imm -4 (0xFE000EE3), pc 0x100 -> imm=0xFFFFFFFC, type=3, target=0x000000FC.
REQ-039 Bench SHALL check: XLEN=64, slli x1,x1,63 (0x03F09093) -> imm=63, type=6; with SHIFT_DECODE=0 -> imm=0x3F, type=1.
REQ-040 Bench SHALL check: out_ready=0 with 3 back-to-back pushes -> in_ready drops after the 2nd push, the 3rd is held off, and the outputs stay stable; raising out_ready then drains the entries in order.
REQ-041 Bench SHALL check: instr 0x0000007F -> illegal=1, type=0, imm=0; and flush at count=2 -> out_valid=0 next cycle.
REQ-042 Bench SHALL check: jal with pc 0xFFFFFFF0 and imm +0x20 -> target=0x00000010 (wrap-around); and rst_n=0 mid-stream -> all outputs 0.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Immediate generator: decodes the RISC-V immediate, class and PC-relative target
// of each offered instruction and buffers the results in a 2-entry ready/valid FIFO.
module imm_gen_pipe #(
  parameter int XLEN         = 32,
  parameter int SHIFT_DECODE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_type,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  typedef enum logic [2:0] {
    T_NONE  = 3'd0,
    T_I     = 3'd1,
    T_S     = 3'd2,
    T_B     = 3'd3,
    T_U     = 3'd4,
    T_J     = 3'd5,
    T_SHAMT = 3'd6,
    T_CSRZ  = 3'd7
  } imm_type_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_type_e       typ;
    logic [XLEN-1:0] target;
    logic            illegal;
  } entry_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_OP_32  = 7'b0111011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  entry_t          dec;
  logic            use_target;
  logic            is_shift;

  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
  // funct3 of 001 (SLLI) or 101 (SRLI/SRAI)
  assign is_shift = (SHIFT_DECODE != 0) && (in_instr[13:12] == 2'b01);

  always_comb begin
    dec        = '0;
    use_target = 1'b0;
    case (in_instr[6:0])
      OP_IMM: begin
        if (is_shift) begin
          dec.typ = T_SHAMT;
          dec.imm = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
        end else begin
          dec.typ = T_I;
          dec.imm = imm_i;
        end
      end
      OP_IMM_32: begin
        if (XLEN != 64) begin
          dec.illegal = 1'b1;
        end else if (is_shift) begin
          dec.typ = T_SHAMT;
          dec.imm = XLEN'(in_instr[24:20]);
        end else begin
          dec.typ = T_I;
          dec.imm = imm_i;
        end
      end
      OP_LOAD, OP_JALR: begin
        dec.typ = T_I;
        dec.imm = imm_i;
      end
      OP_STORE: begin
        dec.typ = T_S;
        dec.imm = imm_s;
      end
      OP_BRANCH: begin
        dec.typ    = T_B;
        dec.imm    = imm_b;
        use_target = 1'b1;
      end
      OP_LUI: begin
        dec.typ = T_U;
        dec.imm = imm_u;
      end
      OP_AUIPC: begin
        dec.typ    = T_U;
        dec.imm    = imm_u;
        use_target = 1'b1;
      end
      OP_JAL: begin
        dec.typ    = T_J;
        dec.imm    = imm_j;
        use_target = 1'b1;
      end
      OP_SYSTEM: begin
        if (in_instr[14]) begin
          dec.typ = T_CSRZ;
          dec.imm = XLEN'(in_instr[19:15]);
        end
      end
      OP_OP: begin
      end
      OP_OP_32: begin
        if (XLEN != 64) dec.illegal = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (use_target) dec.target = in_pc + dec.imm;
  end

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  entry_t     head;
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  // in_ready depends only on the stored count (and reset), never on out_ready
  assign in_ready  = rst_n && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Outputs read as zero whenever nothing is presented, including after reset
  assign head        = mem_q[rd_ptr_q];
  assign out_imm     = out_valid ? head.imm     : '0;
  assign out_type    = out_valid ? head.typ     : T_NONE;
  assign out_target  = out_valid ? head.target  : '0;
  assign out_illegal = out_valid ? head.illegal : 1'b0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed cases plus randomized traffic
// against a queue-based reference model, on RV32 and RV64 (with/without shift decode).
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc64 = '0;
  logic [31:0] in_pc32;

  logic        r32, v32, ill32;
  logic [31:0] imm32, tgt32;
  logic [2:0]  typ32;
  logic        r64, v64, ill64;
  logic [63:0] imm64, tgt64;
  logic [2:0]  typ64;
  logic        r64n, v64n, ill64n;
  logic [63:0] imm64n, tgt64n;
  logic [2:0]  typ64n;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic [63:0] tgt;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } txn_t;

  assign in_pc32 = in_pc64[31:0];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SHIFT_DECODE(1)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_instr(in_instr), .in_pc(in_pc32), .out_valid(v32), .out_ready(out_ready),
    .out_imm(imm32), .out_type(typ32), .out_target(tgt32), .out_illegal(ill32));

  imm_gen_pipe #(.XLEN(64), .SHIFT_DECODE(1)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_instr(in_instr), .in_pc(in_pc64), .out_valid(v64), .out_ready(out_ready),
    .out_imm(imm64), .out_type(typ64), .out_target(tgt64), .out_illegal(ill64));

  imm_gen_pipe #(.XLEN(64), .SHIFT_DECODE(0)) dut64n (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r64n),
    .in_instr(in_instr), .in_pc(in_pc64), .out_valid(v64n), .out_ready(out_ready),
    .out_imm(imm64n), .out_type(typ64n), .out_target(tgt64n), .out_illegal(ill64n));

  // Sign-extend the low 'bits' of v arithmetically
  function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
    logic [63:0] m;
    m = 64'd1 << (bits - 1);
    v = v & ((m << 1) - 64'd1);
    return (v ^ m) - m;
  endfunction

  function automatic exp_t model(input int xlen, input bit sd, input logic [31:0] instr,
                                 input logic [63:0] pc);
    exp_t        e;
    logic [63:0] mask;
    bit          rel;
    bit          shift;
    e     = '{imm: '0, typ: 3'd0, tgt: '0, ill: 1'b0};
    rel   = 1'b0;
    mask  = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
    shift = sd && (instr[14:12] == 3'b001 || instr[14:12] == 3'b101);
    case (instr[6:0])
      7'h13: if (shift) begin
               e.typ = 3'd6;
               e.imm = (xlen == 64) ? 64'(instr[25:20]) : 64'(instr[24:20]);
             end else begin
               e.typ = 3'd1; e.imm = sx(64'(instr[31:20]), 12);
             end
      7'h1B: if (xlen != 64) e.ill = 1'b1;
             else if (shift) begin e.typ = 3'd6; e.imm = 64'(instr[24:20]); end
             else begin e.typ = 3'd1; e.imm = sx(64'(instr[31:20]), 12); end
      7'h03, 7'h67: begin e.typ = 3'd1; e.imm = sx(64'(instr[31:20]), 12); end
      7'h23: begin e.typ = 3'd2; e.imm = sx(64'({instr[31:25], instr[11:7]}), 12); end
      7'h63: begin
               e.typ = 3'd3; rel = 1'b1;
               e.imm = sx(64'({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}), 13);
             end
      7'h37: begin e.typ = 3'd4; e.imm = sx(64'({instr[31:12], 12'b0}), 32); end
      7'h17: begin e.typ = 3'd4; rel = 1'b1; e.imm = sx(64'({instr[31:12], 12'b0}), 32); end
      7'h6F: begin
               e.typ = 3'd5; rel = 1'b1;
               e.imm = sx(64'({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}), 21);
             end
      7'h73: if (instr[14]) begin e.typ = 3'd7; e.imm = 64'(instr[19:15]); end
      7'h33: ;
      7'h3B: if (xlen != 64) e.ill = 1'b1;
      default: e.ill = 1'b1;
    endcase
    e.imm = e.imm & mask;
    if (rel) e.tgt = (pc + e.imm) & mask;
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0]  ops [12];
    logic [31:0] r;
    int          k;
    ops = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h3B};
    r = $urandom;
    k = $urandom_range(0, 12);
    if (k == 12) return r;
    return {r[31:7], ops[k]};
  endfunction

  // Apply one cycle of inputs at the falling edge; outputs are then read 1 time unit later
  task automatic drive(input logic v, input logic [31:0] instr, input logic [63:0] pc,
                       input logic ordy, input logic fl);
    @(negedge clk);
    in_valid  = v;
    in_instr  = instr;
    in_pc64   = pc;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 32'h0200006F, 64'h100, 1'b0, 1'b0);
    drive(1'b1, 32'h0200006F, 64'h100, 1'b0, 1'b0);
    checks++; if (v32 !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %b expected 0", v32); end
    checks++; if (r32 !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_ready: got %b expected 0", r32); end
    checks++; if (imm32 !== 32'h0) begin errors++; $display("[TB] FAIL rst_imm: got %h expected 0", imm32); end
    checks++; if (typ32 !== 3'd0) begin errors++; $display("[TB] FAIL rst_type: got %0d expected 0", typ32); end
    checks++; if (tgt32 !== 32'h0) begin errors++; $display("[TB] FAIL rst_target: got %h expected 0", tgt32); end
    checks++; if (ill32 !== 1'b0) begin errors++; $display("[TB] FAIL rst_illegal: got %b expected 0", ill32); end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    checks++; if (r32 !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_in_ready: got %b expected 1", r32); end
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    checks++; if (v32 !== 1'b0) begin errors++; $display("[TB] FAIL rst_release_valid: got %b expected 0", v32); end
  endtask

  task automatic test_addi();
    drive(1'b1, 32'hFFF00093, 64'h0, 1'b1, 1'b0);
    checks++; if (v32 !== 1'b0) begin errors++; $display("[TB] FAIL addi_latency: got %b expected 0", v32); end
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    checks++; if (v32 !== 1'b1) begin errors++; $display("[TB] FAIL addi_valid: got %b expected 1", v32); end
    checks++; if (imm32 !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL addi_imm: got %h expected ffffffff", imm32); end
    checks++; if (typ32 !== 3'd1) begin errors++; $display("[TB] FAIL addi_type: got %0d expected 1", typ32); end
    checks++; if (tgt32 !== 32'h0) begin errors++; $display("[TB] FAIL addi_target: got %h expected 0", tgt32); end
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    checks++; if (v32 !== 1'b0) begin errors++; $display("[TB] FAIL addi_drained: got %b expected 0", v32); end
  endtask

  task automatic test_branch();
    drive(1'b1, 32'hFE000EE3, 64'h100, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    checks++; if (imm32 !== 32'hFFFFFFFC) begin errors++; $display("[TB] FAIL beq_imm: got %h expected fffffffc", imm32); end
    checks++; if (typ32 !== 3'd3) begin errors++; $display("[TB] FAIL beq_type: got %0d expected 3", typ32); end
    checks++; if (tgt32 !== 32'h000000FC) begin errors++; $display("[TB] FAIL beq_target: got %h expected 000000fc", tgt32); end
  endtask

  task automatic test_shamt();
    drive(1'b1, 32'h03F09093, 64'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    checks++; if (imm64 !== 64'd63) begin errors++; $display("[TB] FAIL slli64_imm: got %h expected 3f", imm64); end
    checks++; if (typ64 !== 3'd6) begin errors++; $display("[TB] FAIL slli64_type: got %0d expected 6", typ64); end
    checks++; if (imm64n !== 64'h3F) begin errors++; $display("[TB] FAIL slli64_nodec_imm: got %h expected 3f", imm64n); end
    checks++; if (typ64n !== 3'd1) begin errors++; $display("[TB] FAIL slli64_nodec_type: got %0d expected 1", typ64n); end
    checks++; if (imm32 !== 32'h1F) begin errors++; $display("[TB] FAIL slli32_imm: got %h expected 1f", imm32); end
    checks++; if (typ32 !== 3'd6) begin errors++; $display("[TB] FAIL slli32_type: got %0d expected 6", typ32); end
  endtask

  task automatic test_illegal();
    drive(1'b1, 32'h0000007F, 64'h40, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    checks++; if (ill32 !== 1'b1) begin errors++; $display("[TB] FAIL illegal_flag: got %b expected 1", ill32); end
    checks++; if (typ32 !== 3'd0) begin errors++; $display("[TB] FAIL illegal_type: got %0d expected 0", typ32); end
    checks++; if (imm32 !== 32'h0) begin errors++; $display("[TB] FAIL illegal_imm: got %h expected 0", imm32); end
    checks++; if (tgt32 !== 32'h0) begin errors++; $display("[TB] FAIL illegal_target: got %h expected 0", tgt32); end
  endtask

  task automatic test_jal_wrap();
    drive(1'b1, 32'h0200006F, 64'hFFFFFFF0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    checks++; if (imm32 !== 32'h20) begin errors++; $display("[TB] FAIL jal_imm: got %h expected 20", imm32); end
    checks++; if (typ32 !== 3'd5) begin errors++; $display("[TB] FAIL jal_type: got %0d expected 5", typ32); end
    checks++; if (tgt32 !== 32'h10) begin errors++; $display("[TB] FAIL jal_wrap_target: got %h expected 10", tgt32); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h00100093, 64'h0, 1'b0, 1'b0);
    checks++; if (r32 !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready0: got %b expected 1", r32); end
    drive(1'b1, 32'h00200093, 64'h0, 1'b0, 1'b0);
    checks++; if (r32 !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready1: got %b expected 1", r32); end
    checks++; if (imm32 !== 32'd1) begin errors++; $display("[TB] FAIL bp_head1: got %h expected 1", imm32); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h00300093, 64'h0, 1'b0, 1'b0);
      checks++; if (r32 !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_ready: got %b expected 0", r32); end
      checks++; if (imm32 !== 32'd1 || typ32 !== 3'd1 || v32 !== 1'b1)
        begin errors++; $display("[TB] FAIL bp_stable: got imm %h type %0d valid %b expected 1/1/1", imm32, typ32, v32); end
    end
    drive(1'b1, 32'h00300093, 64'h0, 1'b1, 1'b0);
    checks++; if (imm32 !== 32'd1) begin errors++; $display("[TB] FAIL bp_drain_a: got %h expected 1", imm32); end
    drive(1'b1, 32'h00300093, 64'h0, 1'b1, 1'b0);
    checks++; if (imm32 !== 32'd2 || r32 !== 1'b1)
      begin errors++; $display("[TB] FAIL bp_drain_b: got imm %h ready %b expected 2/1", imm32, r32); end
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    checks++; if (imm32 !== 32'd3 || v32 !== 1'b1)
      begin errors++; $display("[TB] FAIL bp_drain_c: got imm %h valid %b expected 3/1", imm32, v32); end
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    checks++; if (v32 !== 1'b0) begin errors++; $display("[TB] FAIL bp_empty: got %b expected 0", v32); end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h00100093, 64'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h00200093, 64'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h00300093, 64'h0, 1'b0, 1'b1);
    checks++; if (r32 !== 1'b0) begin errors++; $display("[TB] FAIL flush_preready: got %b expected 0", r32); end
    drive(1'b1, 32'h00300093, 64'h0, 1'b1, 1'b1);
    checks++; if (v32 !== 1'b0) begin errors++; $display("[TB] FAIL flush_full_valid: got %b expected 0", v32); end
    checks++; if (r32 !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready_after: got %b expected 1", r32); end
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    checks++; if (v32 !== 1'b0) begin errors++; $display("[TB] FAIL flush_drops_push: got %b expected 0", v32); end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 32'hFE000EE3, 64'h100, 1'b0, 1'b0);
    drive(1'b1, 32'h0000007F, 64'h100, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
    checks++; if (v32 !== 1'b1 || tgt32 !== 32'hFC)
      begin errors++; $display("[TB] FAIL mid_prefill: got valid %b target %h expected 1/fc", v32, tgt32); end
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    #1;
    checks++; if (r32 !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_ready: got %b expected 0", r32); end
    drive(1'b1, 32'h00100093, 64'h0, 1'b1, 1'b0);
    checks++; if (v32 !== 1'b0 || imm32 !== 32'h0 || typ32 !== 3'd0 || tgt32 !== 32'h0 || ill32 !== 1'b0)
      begin errors++; $display("[TB] FAIL mid_rst_outputs: got valid %b imm %h type %0d target %h illegal %b expected all 0",
                               v32, imm32, typ32, tgt32, ill32); end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    checks++; if (v32 !== 1'b0 || r32 !== 1'b1)
      begin errors++; $display("[TB] FAIL mid_rst_recover: got valid %b ready %b expected 0/1", v32, r32); end
  endtask

  task automatic test_random();
    txn_t        q[$];
    txn_t        t;
    exp_t        e32, e64, e64n;
    logic        v, ordy, fl;
    logic [31:0] instr;
    logic [63:0] pc;
    bit          exp_valid, exp_ready;
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b1);
    for (int cyc = 0; cyc < 400; cyc++) begin
      v     = ($urandom_range(0, 3) != 0);
      ordy  = ($urandom_range(0, 3) != 0);
      fl    = ($urandom_range(0, 24) == 0);
      instr = gen_instr();
      pc    = {$urandom, $urandom};
      drive(v, instr, pc, ordy, fl);
      exp_valid = (q.size() != 0);
      exp_ready = (q.size() != 2);
      checks++; if (v32 !== exp_valid || v64 !== exp_valid || v64n !== exp_valid)
        begin errors++; $display("[TB] FAIL rnd_valid: got %b%b%b expected %b", v32, v64, v64n, exp_valid); end
      checks++; if (r32 !== exp_ready || r64 !== exp_ready || r64n !== exp_ready)
        begin errors++; $display("[TB] FAIL rnd_ready: got %b%b%b expected %b", r32, r64, r64n, exp_ready); end
      if (exp_valid) begin
        t    = q[0];
        e32  = model(32, 1'b1, t.instr, t.pc);
        e64  = model(64, 1'b1, t.instr, t.pc);
        e64n = model(64, 1'b0, t.instr, t.pc);
        checks++; if (imm32 !== e32.imm[31:0] || typ32 !== e32.typ || tgt32 !== e32.tgt[31:0] || ill32 !== e32.ill)
          begin errors++; $display("[TB] FAIL rnd32 instr %h: got %h/%0d/%h/%b expected %h/%0d/%h/%b", t.instr,
                                   imm32, typ32, tgt32, ill32, e32.imm[31:0], e32.typ, e32.tgt[31:0], e32.ill); end
        checks++; if (imm64 !== e64.imm || typ64 !== e64.typ || tgt64 !== e64.tgt || ill64 !== e64.ill)
          begin errors++; $display("[TB] FAIL rnd64 instr %h: got %h/%0d/%h/%b expected %h/%0d/%h/%b", t.instr,
                                   imm64, typ64, tgt64, ill64, e64.imm, e64.typ, e64.tgt, e64.ill); end
        checks++; if (imm64n !== e64n.imm || typ64n !== e64n.typ || tgt64n !== e64n.tgt || ill64n !== e64n.ill)
          begin errors++; $display("[TB] FAIL rnd64n instr %h: got %h/%0d/%h/%b expected %h/%0d/%h/%b", t.instr,
                                   imm64n, typ64n, tgt64n, ill64n, e64n.imm, e64n.typ, e64n.tgt, e64n.ill); end
      end
      if (fl) begin
        q.delete();
      end else begin
        if (exp_valid && ordy) void'(q.pop_front());
        if (v && exp_ready) q.push_back('{instr: instr, pc: pc});
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_shamt();
    test_illegal();
    test_jal_wrap();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
